// File: rtl/maze_pkg.sv
// maze_pkg: shared grid geometry, direction/state encodings and cell helpers for the maze player controller.
package maze_pkg;
    localparam int GRID_N     = 5;
    localparam int CELL_PITCH = 96;
    localparam int ORIGIN_X   = 81;
    localparam int ORIGIN_Y   = 2;
    localparam int START_COL  = 0;
    localparam int START_ROW  = 4;
    localparam int END_COL    = 4;
    localparam int END_ROW    = 0;
    localparam logic [9:0] START_X = 10'(ORIGIN_X + CELL_PITCH * START_COL);
    localparam logic [9:0] START_Y = 10'(ORIGIN_Y + CELL_PITCH * START_ROW);

    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;
    typedef enum logic [1:0] {IDLE, HOLD, WIN} state_t;

    function automatic int cell_idx(input int col, input int row);
        return row * GRID_N + col;
    endfunction

    // Bits are {right, left, down, up}; anything but exactly one high is no direction.
    function automatic dir_t decode_dir(input logic [3:0] lv);
        return lv == 4'b0001 ? DIR_UP :
               lv == 4'b0010 ? DIR_DOWN :
               lv == 4'b0100 ? DIR_LEFT :
               lv == 4'b1000 ? DIR_RIGHT : DIR_NONE;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser followed by a stability counter that qualifies level changes.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic in_clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/maze_player_ctrl.sv
// maze_player_ctrl: debounced button-driven player position for the 5x5 maze with wall/edge rejection and win detect.
// Define MAZE_AUTOREPEAT_EN to re-evaluate a single held direction every REPEAT_CYCLES.
module maze_player_ctrl
    import maze_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = 1_000_000,
    parameter int          REPEAT_CYCLES   = 25_000_000,
    parameter logic [24:0] WALL_MAP        = 25'h0
) (
    input  logic       in_clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_restart,
    output logic [2:0] player_col,
    output logic [2:0] player_row,
    output logic [9:0] player_x,
    output logic [9:0] player_y,
    output logic       move_pulse,
    output logic       block_pulse,
    output logic [7:0] move_count,
    output logic       win
);
    localparam logic [2:0]  LAST     = 3'(GRID_N - 1);
    localparam logic [24:0] WALL_EFF = WALL_MAP
                                       & ~(25'(1) << cell_idx(START_COL, START_ROW))
                                       & ~(25'(1) << cell_idx(END_COL, END_ROW));
    localparam logic [31:0] WALL_EXT = {7'd0, WALL_EFF};

    logic [4:0] raw, lv, lv_q;
    logic       rs_q;
    state_t     state, next;
    dir_t       dir;
    logic [2:0] tcol, trow, col_n, row_n;
    logic [4:0] tidx;
    logic [9:0] x_n, y_n;
    logic [7:0] cnt_n;
    logic       in_grid, ok, eval, restart, accept, block, at_end, rep_fire, win_n;

    assign raw = {btn_restart, btn_right, btn_left, btn_down, btn_up};

    for (genvar i = 0; i < 5; i++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .in_clk (in_clk),
            .rst_n  (rst_n),
            .raw    (raw[i]),
            .level  (lv[i])
        );
    end

    assign dir     = decode_dir(lv_q[3:0]);
    assign in_grid = !((dir == DIR_UP    && player_row == 3'd0) ||
                       (dir == DIR_DOWN  && player_row == LAST) ||
                       (dir == DIR_LEFT  && player_col == 3'd0) ||
                       (dir == DIR_RIGHT && player_col == LAST));
    assign tcol    = dir == DIR_LEFT ? player_col - 3'd1 : dir == DIR_RIGHT ? player_col + 3'd1 : player_col;
    assign trow    = dir == DIR_UP   ? player_row - 3'd1 : dir == DIR_DOWN  ? player_row + 3'd1 : player_row;
    assign tidx    = 5'(cell_idx(int'(tcol), int'(trow)));
    assign ok      = in_grid && !WALL_EXT[tidx];
    assign at_end  = tcol == 3'(END_COL) && trow == 3'(END_ROW);
    assign restart = lv_q[4] && !rs_q;
    assign eval    = dir != DIR_NONE && (state == IDLE || rep_fire) && !restart;
    assign accept  = eval && ok;
    assign block   = eval && !ok;

`ifdef MAZE_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    logic [RW-1:0] rep_cnt;
    logic [3:0]    dir_prev;

    assign rep_fire = state == HOLD && dir != DIR_NONE && lv_q[3:0] == dir_prev
                      && rep_cnt == RW'(REPEAT_CYCLES - 1);

    // Restarts on entering HOLD and whenever the held direction set changes.
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt  <= '0;
            dir_prev <= '0;
        end else begin
            dir_prev <= lv_q[3:0];
            rep_cnt  <= (state != HOLD || dir == DIR_NONE || lv_q[3:0] != dir_prev || rep_fire)
                        ? '0 : rep_cnt + 1'b1;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = restart                          ? HOLD :
               accept && at_end                 ? WIN  :
               state == IDLE && |lv_q[3:0]      ? HOLD :
               state == HOLD && !(|lv_q[3:0])   ? IDLE : state;
    end

    always_comb begin
        col_n = restart ? 3'(START_COL) : accept ? tcol : player_col;
        row_n = restart ? 3'(START_ROW) : accept ? trow : player_row;
        x_n   = restart ? START_X :
                accept && dir == DIR_RIGHT ? player_x + 10'(CELL_PITCH) :
                accept && dir == DIR_LEFT  ? player_x - 10'(CELL_PITCH) : player_x;
        y_n   = restart ? START_Y :
                accept && dir == DIR_DOWN ? player_y + 10'(CELL_PITCH) :
                accept && dir == DIR_UP   ? player_y - 10'(CELL_PITCH) : player_y;
        cnt_n = restart ? 8'd0 : accept && move_count != 8'hFF ? move_count + 8'd1 : move_count;
        win_n = restart ? 1'b0 : accept && at_end ? 1'b1 : win;
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            lv_q        <= '0;
            rs_q        <= 1'b0;
            player_col  <= 3'(START_COL);
            player_row  <= 3'(START_ROW);
            player_x    <= START_X;
            player_y    <= START_Y;
            move_pulse  <= 1'b0;
            block_pulse <= 1'b0;
            move_count  <= 8'd0;
            win         <= 1'b0;
        end else begin
            lv_q        <= lv;
            rs_q        <= lv_q[4];
            player_col  <= col_n;
            player_row  <= row_n;
            player_x    <= x_n;
            player_y    <= y_n;
            move_pulse  <= accept;
            block_pulse <= block;
            move_count  <= cnt_n;
            win         <= win_n;
        end
    end
endmodule

// File: tb/tb_maze_player_ctrl.sv
// tb_maze_player_ctrl: table-driven press vectors with a pulse-event scoreboard for maze_player_ctrl.
module tb_maze_player_ctrl;
    localparam int D  = 4;
    localparam int R  = 16;
`ifdef MAZE_AUTOREPEAT_EN
    localparam int HL = 14;
`else
    localparam int HL = 40;
`endif
    localparam logic [4:0] U = 5'b00001, DN = 5'b00010, L = 5'b00100, RT = 5'b01000, RS = 5'b10000;

    logic       in_clk = 1'b0;
    logic       rst_n  = 1'b0;
    logic [4:0] btn    = '0;
    logic [2:0] col, row, w_col, w_row;
    logic [9:0] x, y, w_x, w_y;
    logic       mp, bp, win, w_mp, w_bp, w_win;
    logic [7:0] cnt, w_cnt;

    int checks = 0, failures = 0, b2 = 0, m2 = 0;
    logic [39:0] act_q[$], exp_q[$];

    typedef struct {
        logic [4:0] btn;
        int         hold;
        int         kind;
        int         col;
        int         row;
        int         cnt;
        int         win;
    } vec_t;
    vec_t vecs[20];

    always #5 in_clk = ~in_clk;

    maze_player_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R), .WALL_MAP(25'h0)) dut (
        .in_clk(in_clk), .rst_n(rst_n),
        .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]), .btn_restart(btn[4]),
        .player_col(col), .player_row(row), .player_x(x), .player_y(y),
        .move_pulse(mp), .block_pulse(bp), .move_count(cnt), .win(win)
    );

    maze_player_ctrl #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R), .WALL_MAP(25'h200000)) dut_w (
        .in_clk(in_clk), .rst_n(rst_n),
        .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]), .btn_restart(btn[4]),
        .player_col(w_col), .player_row(w_row), .player_x(w_x), .player_y(w_y),
        .move_pulse(w_mp), .block_pulse(w_bp), .move_count(w_cnt), .win(w_win)
    );

    function automatic logic [39:0] pk(input int k, input int c, input int r, input int px, input int py,
                                       input int n, input int w);
        return {2'b0, 3'(k), 3'(c), 3'(r), 10'(px), 10'(py), 8'(n), 1'(w)};
    endfunction

    function automatic logic [39:0] model(input int k, input int c, input int r, input int n, input int w);
        return pk(k, c, r, 81 + 96 * c, 2 + 96 * r, n, w);
    endfunction

    always @(negedge in_clk) begin
        if (rst_n) begin
            if (mp || bp)
                act_q.push_back(pk(mp && bp ? 3 : mp ? 1 : 2, int'(col), int'(row), int'(x), int'(y),
                                   int'(cnt), int'(win)));
            if (w_bp) b2++;
            if (w_mp) m2++;
        end
    end

    task automatic check(input string nm, input int idx, input logic [39:0] got, input logic [39:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s[%0d] got=%h want=%h", nm, idx, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge in_clk);
        #1;
    endtask

    task automatic press(input logic [4:0] b, input int hold);
        btn = b;
        tick(hold);
        btn = '0;
        tick(14);
    endtask

    task automatic drain(input int idx);
        check("event_count", idx, 40'(act_q.size()), 40'(exp_q.size()));
        while (act_q.size() > 0 && exp_q.size() > 0)
            check("event", idx, act_q.pop_front(), exp_q.pop_front());
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic check_pos(input int idx, input int c, input int r, input int n, input int w);
        check("pos", idx, pk(int'({mp, bp}), int'(col), int'(row), int'(x), int'(y), int'(cnt), int'(win)),
              model(0, c, r, n, w));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn   = '0;
        tick(3);
        rst_n = 1'b1;
        tick(3);
    endtask

    initial begin
        vecs[0]  = '{RT,      10, 1, 1, 4, 1, 0};
        vecs[1]  = '{RT,      HL, 1, 2, 4, 2, 0};
        vecs[2]  = '{DN,      10, 2, 2, 4, 2, 0};
        vecs[3]  = '{U,        2, 0, 2, 4, 2, 0};
        vecs[4]  = '{U | L,   20, 0, 2, 4, 2, 0};
        vecs[5]  = '{L,       10, 1, 1, 4, 3, 0};
        vecs[6]  = '{RS | RT, 10, 0, 0, 4, 0, 0};
        vecs[7]  = '{L,       10, 2, 0, 4, 0, 0};
        vecs[8]  = '{U,       10, 1, 0, 3, 1, 0};
        vecs[9]  = '{U,       10, 1, 0, 2, 2, 0};
        vecs[10] = '{U,       10, 1, 0, 1, 3, 0};
        vecs[11] = '{U,       10, 1, 0, 0, 4, 0};
        vecs[12] = '{RT,      10, 1, 1, 0, 5, 0};
        vecs[13] = '{RT,      10, 1, 2, 0, 6, 0};
        vecs[14] = '{RT,      10, 1, 3, 0, 7, 0};
        vecs[15] = '{RT,      10, 1, 4, 0, 8, 1};
        vecs[16] = '{RT,      10, 0, 4, 0, 8, 1};
        vecs[17] = '{DN,      10, 0, 4, 0, 8, 1};
        vecs[18] = '{RS,      10, 0, 0, 4, 0, 0};
        vecs[19] = '{U,       10, 1, 0, 3, 1, 0};

        do_reset();
        check_pos(-1, 0, 4, 0, 0);
        tick(10);
        drain(-1);

        for (int i = 0; i < 20; i++) begin
            if (vecs[i].kind != 0)
                exp_q.push_back(model(vecs[i].kind, vecs[i].col, vecs[i].row, vecs[i].cnt, vecs[i].win));
            press(vecs[i].btn, vecs[i].hold);
            drain(i);
            check_pos(i, vecs[i].col, vecs[i].row, vecs[i].cnt, vecs[i].win);
            if (i == 0) begin
                check("wall_col", i, 40'(w_col), 40'd0);
                check("wall_blocks", i, 40'(b2), 40'd1);
                check("wall_moves", i, 40'(m2), 40'd0);
            end
        end

        // Reset landing mid-debounce: nothing may surface.
        do_reset();
        btn = RT;
        tick(4);
        rst_n = 1'b0;
        tick(2);
        btn = '0;
        tick(2);
        rst_n = 1'b1;
        tick(15);
        drain(100);
        check_pos(100, 0, 4, 0, 0);

        // Reset landing mid-HOLD after one accepted move.
        exp_q.push_back(model(1, 1, 4, 1, 0));
        btn = RT;
        tick(12);
        rst_n = 1'b0;
        tick(2);
        btn = '0;
        tick(2);
        rst_n = 1'b1;
        tick(15);
        drain(101);
        check_pos(101, 0, 4, 0, 0);

`ifdef MAZE_AUTOREPEAT_EN
        do_reset();
        for (int c = 1; c <= 4; c++)
            exp_q.push_back(model(1, c, 4, c, 0));
        exp_q.push_back(model(2, 4, 4, 4, 0));
        press(RT, 70);
        drain(200);
        check_pos(200, 4, 4, 4, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
